// File: rtl/snoop_log_pkg.sv
// Shared types and constants for the snoop capture-log arbiter.
package snoop_log_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        ABORT   = 2'd3
    } state_e;

    localparam logic [3:0] HDR_TAG    = 4'hA;
    localparam logic [7:0] ABORT_BYTE = 8'hEE;

    // Width of a port index; never narrower than one bit.
    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snoop_log_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = W'((int'(ptr) + i) % N);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_log_arbiter.sv
// Packet round-robin arbiter merging per-port snoop byte streams into one log stream.
// Optional payload-stall watchdog with ABORT trailer is built when SNOOP_LOG_TIMEOUT_EN is defined.
module snoop_log_arbiter
    import snoop_log_pkg::*;
#(
    parameter int  NUM_PORTS   = 4,
    parameter int  DATA_W      = 8,
    parameter int  TIMEOUT_CYC = 4800,
    localparam int PW          = port_w(NUM_PORTS)
) (
    input  logic                        clk_48mhz,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data,
    input  logic [NUM_PORTS-1:0]        req_last,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic                        log_valid,
    output logic [DATA_W-1:0]           log_data,
    output logic                        log_last,
    input  logic                        log_ready,
    output logic [PW-1:0]               grant_port,
    output logic                        busy,
    output logic [15:0]                 drop_count
);

    if (DATA_W != 8 || NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("snoop_log_arbiter: unsupported parameter set");
    end

    state_e        state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] pick_idx;
    logic          pick_found;
    logic [PW-1:0] next_ptr;

    logic [DATA_W-1:0] port_data [NUM_PORTS];
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_split
        assign port_data[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign sel_data  = port_data[grant_q];
    assign next_ptr  = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    rr_pick #(
        .N (NUM_PORTS),
        .W (PW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef SNOOP_LOG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_q, wd_d;
    logic [15:0]     drop_q, drop_d;
    assign drop_count = drop_q;
`else
    assign drop_count = 16'd0;
`endif

    // Stream outputs decode from state; PAYLOAD is a zero-latency passthrough.
    always_comb begin
        log_valid = 1'b0;
        log_data  = '0;
        log_last  = 1'b0;
        req_ready = '0;
        case (state_q)
            HEADER: begin
                log_valid = 1'b1;
                log_data  = DATA_W'({HDR_TAG, 4'(grant_q)});
            end
            PAYLOAD: begin
                log_valid          = sel_valid;
                log_data           = sel_data;
                log_last           = sel_last;
                req_ready[grant_q] = log_ready;
            end
`ifdef SNOOP_LOG_TIMEOUT_EN
            ABORT: begin
                log_valid = 1'b1;
                log_data  = DATA_W'(ABORT_BYTE);
                log_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
`ifdef SNOOP_LOG_TIMEOUT_EN
        wd_d     = wd_q;
        drop_d   = drop_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (log_ready) begin
                    state_d = PAYLOAD;
`ifdef SNOOP_LOG_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end
            PAYLOAD: begin
                if (sel_valid && log_ready && sel_last) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
`ifdef SNOOP_LOG_TIMEOUT_EN
                // Only source starvation counts; sink backpressure holds the count.
                if (sel_valid) begin
                    if (log_ready) wd_d = '0;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ABORT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
`ifdef SNOOP_LOG_TIMEOUT_EN
            ABORT: begin
                if (log_ready) begin
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
`ifdef SNOOP_LOG_TIMEOUT_EN
            wd_q     <= '0;
            drop_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef SNOOP_LOG_TIMEOUT_EN
            wd_q     <= wd_d;
            drop_q   <= drop_d;
`endif
        end
    end

    assign grant_port = grant_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_snoop_log_arbiter.sv
// Bench for snoop_log_arbiter: per-port source queues, log-side scoreboard, directed and random packets.
module tb_snoop_log_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;

    logic           clk_48mhz = 1'b0;
    logic           reset     = 1'b1;
    logic [NP-1:0]  req_valid = '0;
    logic [NP*DW-1:0] req_data = '0;
    logic [NP-1:0]  req_last  = '0;
    logic [NP-1:0]  req_ready;
    logic           log_valid;
    logic [DW-1:0]  log_data;
    logic           log_last;
    logic           log_ready = 1'b0;
    logic [1:0]     grant_port;
    logic           busy;
    logic [15:0]    drop_count;

    logic [8:0]     src_q [NP][$];
    logic [8:0]     exp_q [$];
    logic [NP-1:0]  pop_pend   = '0;
    logic           rand_ready = 1'b0;
    logic           prev_hold  = 1'b0;
    logic [8:0]     prev_byte  = '0;
    int             total_cnt  = 0;
    int             bad_cnt    = 0;

    snoop_log_arbiter #(
        .NUM_PORTS   (NP),
        .DATA_W      (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_48mhz  (clk_48mhz),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .log_valid  (log_valid),
        .log_data   (log_data),
        .log_last   (log_last),
        .log_ready  (log_ready),
        .grant_port (grant_port),
        .busy       (busy),
        .drop_count (drop_count)
    );

    // Clock and global time bound
    always #10 clk_48mhz = ~clk_48mhz;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=still running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_src(input int p, input logic last, input logic [7:0] data);
        src_q[p].push_back({last, data});
    endtask

    task automatic push_exp(input logic last, input logic [7:0] data);
        exp_q.push_back({last, data});
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < NP; i++)
            if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0 || src_pending()) && n < budget) begin
            @(posedge clk_48mhz); #2;
            n++;
        end
        check({tag, "_drain"}, 32'(n < budget), 32'd1);
    endtask

    // Source driver: retire accepted bytes, present queue heads
    always @(posedge clk_48mhz) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (pop_pend[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            pop_pend[i] = 1'b0;
            if (src_q[i].size() != 0) begin
                req_valid[i]        = 1'b1;
                req_data[i*DW +: DW] = src_q[i][0][7:0];
                req_last[i]         = src_q[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]         = 1'b0;
            end
        end
        if (rand_ready) log_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard / monitor on the falling edge
    always @(negedge clk_48mhz) begin
        logic [8:0] e;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check("hold_stable", {23'd0, log_valid, log_last, log_data}, {23'd0, 1'b1, prev_byte});
            for (int i = 0; i < NP; i++)
                if (req_valid[i] && req_ready[i]) pop_pend[i] = 1'b1;
            if (log_valid && log_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("log_byte", {23'd0, log_last, log_data}, {23'd0, e});
                end
            end
            prev_hold = log_valid && !log_ready;
            prev_byte = {log_last, log_data};
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(log_valid), 32'd0);
        check({tag, "_data"},  32'(log_data),  32'd0);
        check({tag, "_last"},  32'(log_last),  32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_grant"}, 32'(grant_port), 32'd0);
        check({tag, "_drop"},  32'(drop_count), 32'd0);
    endtask

    initial begin
        bit hit;
        int p;
        int n;

        // Reset
        reset = 1'b1;
        repeat (3) @(posedge clk_48mhz);
        #2;
        check_reset_vals("rst");
        reset     = 1'b0;
        log_ready = 1'b1;

        // Single port 2, three bytes, arbitration latency
        @(negedge clk_48mhz);
        push_src(2, 1'b0, 8'h11); push_src(2, 1'b0, 8'h22); push_src(2, 1'b1, 8'h33);
        push_exp(1'b0, 8'hA2); push_exp(1'b0, 8'h11); push_exp(1'b0, 8'h22); push_exp(1'b1, 8'h33);
        @(posedge clk_48mhz); #2;
        check("lat_idle_valid", 32'(log_valid), 32'd0);
        check("lat_idle_busy",  32'(busy),      32'd0);
        @(posedge clk_48mhz); #2;
        check("lat_hdr_valid", 32'(log_valid), 32'd1);
        check("lat_hdr_data",  32'(log_data),  32'hA2);
        check("lat_hdr_grant", 32'(grant_port), 32'd2);
        check("lat_hdr_busy",  32'(busy),      32'd1);
        wait_idle("single", 40);
        check("single_busy_low",   32'(busy),       32'd0);
        check("single_grant_hold", 32'(grant_port), 32'd2);

        // Contention from rr_ptr=0, with re-requests on ports 0 and 2
        reset = 1'b1;
        @(posedge clk_48mhz); #2;
        reset = 1'b0;
        @(negedge clk_48mhz);
        for (int i = 0; i < NP; i++) push_src(i, 1'b1, 8'(8'h50 + i));
        push_src(0, 1'b1, 8'h60);
        push_src(2, 1'b1, 8'h62);
        for (int i = 0; i < NP; i++) begin
            push_exp(1'b0, 8'(8'hA0 + i));
            push_exp(1'b1, 8'(8'h50 + i));
        end
        push_exp(1'b0, 8'hA0); push_exp(1'b1, 8'h60);
        push_exp(1'b0, 8'hA2); push_exp(1'b1, 8'h62);
        wait_idle("contend", 80);
        check("contend_grant_last", 32'(grant_port), 32'd2);

        // Backpressure on port 1: log_ready toggles 1,0,1,0
        @(negedge clk_48mhz);
        push_src(1, 1'b0, 8'h31); push_src(1, 1'b0, 8'h32);
        push_src(1, 1'b0, 8'h33); push_src(1, 1'b1, 8'h34);
        push_exp(1'b0, 8'hA1);
        push_exp(1'b0, 8'h31); push_exp(1'b0, 8'h32);
        push_exp(1'b0, 8'h33); push_exp(1'b1, 8'h34);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk_48mhz); #2;
            log_ready = (k % 2 == 0);
            #1;
            if (busy && log_valid && log_data != 8'hA1)
                check("rdy_mirror", 32'(req_ready), {28'd0, 2'b00, log_ready, 1'b0});
        end
        log_ready = 1'b1;
        wait_idle("bp", 40);

        // Reset after two payload bytes of port 0
        @(negedge clk_48mhz);
        push_src(0, 1'b0, 8'h71); push_src(0, 1'b0, 8'h72); push_src(0, 1'b0, 8'h73);
        push_src(0, 1'b0, 8'h74); push_src(0, 1'b1, 8'h75);
        push_exp(1'b0, 8'hA0); push_exp(1'b0, 8'h71); push_exp(1'b0, 8'h72);
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(posedge clk_48mhz); #2;
            if (exp_q.size() == 0) hit = 1'b1;
        end
        check("mid_rst_reached", 32'(hit), 32'd1);
        log_ready = 1'b0;
        reset     = 1'b1;
        src_q[0].delete();
        @(posedge clk_48mhz); #2;
        check_reset_vals("mid_rst");
        reset     = 1'b0;
        log_ready = 1'b1;
        @(negedge clk_48mhz);
        push_src(1, 1'b1, 8'h81);
        push_src(3, 1'b1, 8'h83);
        push_exp(1'b0, 8'hA1); push_exp(1'b1, 8'h81);
        push_exp(1'b0, 8'hA3); push_exp(1'b1, 8'h83);
        wait_idle("post_rst", 40);

        // Random single-port packets under random sink backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_48mhz);
            p = $urandom_range(0, NP - 1);
            n = $urandom_range(1, 4);
            push_exp(1'b0, 8'hA0 | 8'(p));
            for (int b = 0; b < n; b++) begin
                logic [7:0] d;
                d = 8'($urandom_range(0, 255));
                push_src(p, (b == n - 1), d);
                push_exp((b == n - 1), d);
            end
            wait_idle("rand", 80);
        end
        rand_ready = 1'b0;
        @(posedge clk_48mhz); #2;
        log_ready = 1'b1;

        // Port 3 stalls mid-packet while port 0 waits
        @(negedge clk_48mhz);
        push_src(3, 1'b0, 8'h91);
        push_exp(1'b0, 8'hA3); push_exp(1'b0, 8'h91);
        repeat (5) @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        push_src(0, 1'b1, 8'hA5);
`ifdef SNOOP_LOG_TIMEOUT_EN
        push_exp(1'b1, 8'hEE);
        push_exp(1'b0, 8'hA0); push_exp(1'b1, 8'hA5);
        wait_idle("tmo_abort", 60);
        check("tmo_drop", 32'(drop_count), 32'd1);
        @(negedge clk_48mhz);
        push_src(3, 1'b1, 8'h92);
        push_exp(1'b0, 8'hA3); push_exp(1'b1, 8'h92);
        wait_idle("tmo_resume", 40);
        check("tmo_drop_after", 32'(drop_count), 32'd1);
`else
        repeat (20) @(posedge clk_48mhz);
        #2;
        check("stall_busy",  32'(busy),         32'd1);
        check("stall_grant", 32'(grant_port),   32'd3);
        check("stall_valid", 32'(log_valid),    32'd0);
        check("stall_drop",  32'(drop_count),   32'd0);
        check("stall_expq",  32'(exp_q.size()), 32'd0);
        @(negedge clk_48mhz);
        push_src(3, 1'b1, 8'h92);
        push_exp(1'b1, 8'h92);
        push_exp(1'b0, 8'hA0); push_exp(1'b1, 8'hA5);
        wait_idle("stall_resume", 40);
        check("stall_drop_after", 32'(drop_count), 32'd0);
`endif

        check("final_expq", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
